// File: rtl/ssd1306_spi_engine.sv
// rtl/ssd1306_spi_engine.sv - SSD1306 byte FIFO, CPOL=1/CPHA=1 SPI shifter and panel power sequencer
module ssd1306_spi_engine #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int T_VDD      = 100000,
    parameter int T_RES      = 300,
    parameter int T_VBAT     = 10000000
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_areset,
    input  logic                          pwr_on,
    input  logic [7:0]                    s_tdata,
    input  logic                          s_tdc,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic                          SDIN,
    output logic                          SCLK,
    output logic                          DC,
    output logic                          CS,
    output logic                          RES,
    output logic                          VBAT,
    output logic                          VDD,
    output logic                          busy,
    output logic                          pwr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int T_MX1 = (T_VDD > T_RES) ? T_VDD : T_RES;
    localparam int T_MAX = (T_MX1 > T_VBAT) ? T_MX1 : T_VBAT;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam int DW    = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {
        OFF, VDD_WAIT, RES_LOW, RES_WAIT, VBAT_WAIT, READY, DRAIN, VBAT_OFF
    } pstate_t;

    logic            clk, rst;
    assign clk = s00_axi_aclk;
    assign rst = s00_axi_areset;

    // FIFO: entries are {dc, byte}
    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            s_tready_q, s_tready_d;
    logic            wr_en, rd_en;
    logic [8:0]      head;

    assign wr_en = s_tvalid && s_tready_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en)
            count_d = count_q + 1'b1;
        else if (!wr_en && rd_en)
            count_d = count_q - 1'b1;
    end
    assign s_tready_d = (count_d != (AW+1)'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= {s_tdc, s_tdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s_tready_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            s_tready_q <= s_tready_d;
        end
    end

    // Power sequencer
    pstate_t         pstate_q, pstate_d;
    logic [CW-1:0]   tcnt_q, tcnt_d;
    logic            vdd_q, vdd_d, res_q, res_d, vbat_q, vbat_d, prdy_q, prdy_d;
    logic            active_q, active_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_q <= OFF;
            tcnt_q   <= '0;
            vdd_q    <= 1'b1;
            res_q    <= 1'b1;
            vbat_q   <= 1'b1;
            prdy_q   <= 1'b0;
        end else begin
            pstate_q <= pstate_d;
            tcnt_q   <= tcnt_d;
            vdd_q    <= vdd_d;
            res_q    <= res_d;
            vbat_q   <= vbat_d;
            prdy_q   <= prdy_d;
        end
    end

    always_comb begin
        pstate_d = pstate_q;
        unique case (pstate_q)
            OFF:       if (pwr_on) pstate_d = VDD_WAIT;
            VDD_WAIT:  if (tcnt_q == CW'(T_VDD - 1))  pstate_d = RES_LOW;
            RES_LOW:   if (tcnt_q == CW'(T_RES - 1))  pstate_d = RES_WAIT;
            RES_WAIT:  if (tcnt_q == CW'(T_RES - 1))  pstate_d = VBAT_WAIT;
            VBAT_WAIT: if (tcnt_q == CW'(T_VBAT - 1)) pstate_d = READY;
            READY:     if (!pwr_on) pstate_d = DRAIN;
            DRAIN: begin
                if (pwr_on)
                    pstate_d = READY;
                else if (count_q == '0 && !active_q)
                    pstate_d = VBAT_OFF;
            end
            VBAT_OFF:  if (tcnt_q == CW'(T_VBAT - 1)) pstate_d = OFF;
            default:   pstate_d = OFF;
        endcase
        tcnt_d = (pstate_d != pstate_q) ? '0 : tcnt_q + 1'b1;
    end

    // Supply/reset pins are a pure function of the state being entered
    always_comb begin
        vdd_d  = (pstate_d == OFF);
        res_d  = (pstate_d != RES_LOW);
        vbat_d = !(pstate_d inside {VBAT_WAIT, READY, DRAIN});
        prdy_d = (pstate_d inside {READY, DRAIN});
    end

    // SPI shifter; sh_q holds the bits not yet presented on SDIN
    logic [6:0]      sh_q, sh_d;
    logic [2:0]      bit_q, bit_d;
    logic [DW-1:0]   div_q, div_d;
    logic            high_q, high_d;
    logic            sclk_q, sclk_d, sdin_q, sdin_d, cs_q, cs_d, dc_q, dc_d;
    logic            busy_q, busy_d;
    logic            can_load, load;

    always_comb begin
        active_d = active_q;
        sh_d     = sh_q;
        bit_d    = bit_q;
        div_d    = div_q;
        high_d   = high_q;
        sclk_d   = sclk_q;
        sdin_d   = sdin_q;
        cs_d     = cs_q;
        dc_d     = dc_q;
        rd_en    = 1'b0;
        load     = 1'b0;
        can_load = (pstate_q == READY || pstate_q == DRAIN) && (count_q != '0);
        if (!active_q) begin
            load = can_load;
        end else if (div_q == DW'(CLK_DIV - 1)) begin
            div_d = '0;
            if (!high_q) begin
                high_d = 1'b1;
                sclk_d = 1'b1;
            end else if (bit_q == 3'd7) begin
                if (can_load) begin
                    load = 1'b1;
                end else begin
                    active_d = 1'b0;
                    cs_d     = 1'b1;
                    sdin_d   = 1'b0;
                end
            end else begin
                bit_d  = bit_q + 1'b1;
                sdin_d = sh_q[6];
                sh_d   = {sh_q[5:0], 1'b0};
                high_d = 1'b0;
                sclk_d = 1'b0;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
        // Back-to-back load overrides the byte-end idle so CS never gaps
        if (load) begin
            rd_en    = 1'b1;
            active_d = 1'b1;
            sh_d     = head[6:0];
            sdin_d   = head[7];
            dc_d     = head[8];
            cs_d     = 1'b0;
            sclk_d   = 1'b0;
            high_d   = 1'b0;
            bit_d    = '0;
            div_d    = '0;
        end
        busy_d = (count_d != '0) || active_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sh_q     <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            high_q   <= 1'b0;
            sclk_q   <= 1'b1;
            sdin_q   <= 1'b0;
            cs_q     <= 1'b1;
            dc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            high_q   <= high_d;
            sclk_q   <= sclk_d;
            sdin_q   <= sdin_d;
            cs_q     <= cs_d;
            dc_q     <= dc_d;
            busy_q   <= busy_d;
        end
    end

    assign s_tready   = s_tready_q;
    assign SDIN       = sdin_q;
    assign SCLK       = sclk_q;
    assign DC         = dc_q;
    assign CS         = cs_q;
    assign RES        = res_q;
    assign VBAT       = vbat_q;
    assign VDD        = vdd_q;
    assign busy       = busy_q;
    assign pwr_ready  = prdy_q;
    assign fifo_level = count_q;
endmodule

// File: tb/tb_ssd1306_spi_engine.sv
// tb/tb_ssd1306_spi_engine.sv - directed bench with SPI receiver and byte scoreboard
module tb_ssd1306_spi_engine;
    localparam int CLK_DIV = 2, DEPTH = 16, T_VDD = 5, T_RES = 3, T_VBAT = 7;

    logic       clk = 1'b0, rst = 1'b1, pwr_on = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tdc = 1'b0, s_tvalid = 1'b0;
    logic       s_tready, SDIN, SCLK, DC, CS, RES, VBAT, VDD, busy, pwr_ready;
    logic [4:0] fifo_level;

    ssd1306_spi_engine #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .T_VDD(T_VDD),
                         .T_RES(T_RES), .T_VBAT(T_VBAT)) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst), .pwr_on(pwr_on),
        .s_tdata(s_tdata), .s_tdc(s_tdc), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .SDIN(SDIN), .SCLK(SCLK), .DC(DC), .CS(CS), .RES(RES), .VBAT(VBAT), .VDD(VDD),
        .busy(busy), .pwr_ready(pwr_ready), .fifo_level(fifo_level));

    always #5 clk = ~clk;

    int         n_checks = 0, n_pass = 0;
    logic [8:0] sb_q [$];
    int         rises = 0, rx_count = 0, idle_viol = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // SPI receiver: captures SDIN/DC on each SCLK rise, compares full bytes
    int         bitn = 0;
    logic       sclk_prev = 1'b1;
    logic [7:0] rx_sh = 8'h00;
    logic       rx_dc = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            bitn      = 0;
            sclk_prev = 1'b1;
        end else begin
            if (CS === 1'b1 && (SCLK !== 1'b1 || SDIN !== 1'b0)) idle_viol++;
            if (sclk_prev === 1'b0 && SCLK === 1'b1) begin
                rises++;
                rx_sh = {rx_sh[6:0], SDIN};
                rx_dc = DC;
                bitn++;
                if (bitn == 8) begin
                    bitn = 0;
                    rx_count++;
                    if (sb_q.size() == 0) check("rx_unexpected", 1, 0);
                    else check("rx_byte", {23'd0, rx_dc, rx_sh}, {23'd0, sb_q.pop_front()});
                end
            end
            sclk_prev = SCLK;
        end
    end

    task automatic push(input logic dc, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        s_tvalid = 1'b1; s_tdata = d; s_tdc = dc;
        while (s_tready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) check("push_timeout", 1, 0);
        else sb_q.push_back({dc, d});
    endtask

    task automatic cs_window(output int low, output int high);
        int t = 0;
        low = 0; high = 0;
        while (CS !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("cs_start_timeout", 1, 0);
        while (CS === 1'b0 && low < 1000) begin
            if (SCLK === 1'b1) high++;
            @(negedge clk); low++;
        end
    endtask

    logic rec_vdd [20], rec_res [20], rec_vbat [20], rec_rdy [20];
    int   low, high, t, r0, c0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {20'd0, SCLK, SDIN, DC, CS, RES, VDD, VBAT, s_tready, busy, pwr_ready, fifo_level},
              {20'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
        rst = 1'b0;

        // Fill the FIFO while powered off
        for (int i = 0; i < DEPTH; i++) push(i[0], 8'h10 + 8'(i * 7));
        @(negedge clk);
        s_tvalid = 1'b1; s_tdata = 8'hEE; s_tdc = 1'b0;
        check("full_tready", {31'd0, s_tready}, 0);
        check("full_level", {27'd0, fifo_level}, DEPTH);
        repeat (5) @(negedge clk);
        check("full_hold_level", {27'd0, fifo_level}, DEPTH);
        check("off_no_sclk", rises, 0);
        s_tvalid = 1'b0;

        // Power-up timing, edge k counted from the pwr_on rise
        pwr_on = 1'b1;
        rec_vdd[0] = VDD; rec_res[0] = RES; rec_vbat[0] = VBAT; rec_rdy[0] = pwr_ready;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk); #1;
            rec_vdd[k] = VDD; rec_res[k] = RES; rec_vbat[k] = VBAT; rec_rdy[k] = pwr_ready;
        end
        check("vdd_fall", {30'd0, rec_vdd[0], rec_vdd[1]}, 2'b10);
        check("res_pulse", {27'd0, rec_res[5], rec_res[6], rec_res[7], rec_res[8], rec_res[9]}, 5'b10001);
        check("vbat_fall", {30'd0, rec_vbat[11], rec_vbat[12]}, 2'b10);
        check("pwr_ready_rise", {30'd0, rec_rdy[18], rec_rdy[19]}, 2'b01);
        check("powerup_no_sclk", rises, 0);

        t = 0;
        while ((sb_q.size() != 0 || busy !== 1'b0) && t < 2000) begin @(negedge clk); t++; end
        check("fifo_drained", {31'd0, t < 2000}, 1);
        check("rx_count_16", rx_count, DEPTH);

        // Single command byte
        r0 = rises;
        push(1'b0, 8'hA5);
        @(negedge clk); s_tvalid = 1'b0;
        cs_window(low, high);
        check("a5_cs_low", low, 16 * CLK_DIV);
        check("a5_sclk_high", high, 8 * CLK_DIV);
        check("a5_rises", rises - r0, 8);
        check("a5_busy_end", {31'd0, busy}, 0);
        check("a5_sb_empty", sb_q.size(), 0);

        // Two bytes back-to-back, command then data
        r0 = rises;
        push(1'b0, 8'hAF);
        push(1'b1, 8'h3C);
        @(negedge clk); s_tvalid = 1'b0;
        cs_window(low, high);
        check("b2b_cs_low", low, 32 * CLK_DIV);
        check("b2b_sclk_high", high, 16 * CLK_DIV);
        check("b2b_rises", rises - r0, 16);
        check("b2b_dc_last", {31'd0, DC}, 1);

        // Power-down with bytes queued
        c0 = rx_count;
        push(1'b1, 8'h01);
        push(1'b1, 8'h80);
        push(1'b0, 8'h7E);
        @(negedge clk); s_tvalid = 1'b0; pwr_on = 1'b0;
        t = 0;
        while (VBAT !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        check("drain_vbat_timeout", {31'd0, t < 1000}, 1);
        check("drain_rx", rx_count - c0, 3);
        check("drain_idle", {28'd0, CS, busy, VDD, pwr_ready}, 4'b1000);
        t = 0;
        while (VDD !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        check("vbat_to_vdd", t, T_VBAT);

        // Reset in the middle of bit 4
        pwr_on = 1'b1;
        t = 0;
        while (pwr_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        check("repower_ready", {31'd0, pwr_ready}, 1);
        push(1'b0, 8'h5A);
        @(negedge clk); s_tvalid = 1'b0;
        t = 0;
        while (CS !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        repeat (8 * CLK_DIV + 1) @(negedge clk);
        check("mid_byte_cs", {31'd0, CS}, 0);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        check("reset_mid_byte",
              {25'd0, CS, SCLK, VDD, VBAT, pwr_ready, busy, fifo_level == 5'd0},
              {25'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        @(negedge clk); rst = 1'b0; pwr_on = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_violations", idle_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
